// File: rtl/conv1d_sram_reader.sv
// conv1d_sram_reader
//   Streaming read master for the conv1d accelerator. Fetches len_i 32-bit
//   words starting at base_addr_i from a fixed-latency (1 cycle) SRAM and
//   presents them as a valid/ready stream through a small output FIFO.
//   Requests are only issued while the FIFO has room for every response
//   still in flight, so backpressure never drops data (the SRAM has no grant).
//
// Optional feature: define CONV1D_SRAM_RD_STRIDE_EN to add stride_i, a byte
//   stride latched at start (low two bits ignored). Without it, consecutive
//   words are read (increment of 4).
//
// Ports:
//   clk_i, rst_i       clock, asynchronous active-high reset
//   start_i            start pulse, only looked at while idle
//   base_addr_i        byte address of the first word ([1:0] forced to 0)
//   len_i              number of words to read
//   stride_i           (optional) byte stride per word
//   busy_o             transfer in progress
//   done_o             one-cycle pulse with the final stream handshake
//   sram_req_o         {req, we, be[3:0], addr[31:0], wdata[31:0]}
//   sram_rsp_i         read data, valid the cycle after a request
//   data_o, valid_o    output stream (FIFO head)
//   ready_i            output stream ready
module conv1d_sram_reader #(
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_W      = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [31:0]      base_addr_i,
  input  logic [LEN_W-1:0] len_i,
`ifdef CONV1D_SRAM_RD_STRIDE_EN
  input  logic [15:0]      stride_i,
`endif
  output logic             busy_o,
  output logic             done_o,
  output logic [69:0]      sram_req_o,
  input  logic [31:0]      sram_rsp_i,
  output logic [31:0]      data_o,
  output logic             valid_o,
  input  logic             ready_i
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_L = FIFO_DEPTH[CNT_W:0];

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t           r_state, w_state_nxt;
  logic [31:0]      r_addr;
  logic [LEN_W-1:0] r_issue_rem;
  logic [LEN_W-1:0] r_pop_rem;
  logic             r_rsp_vld_p1;   // a request went out last cycle; its data is on sram_rsp_i now
  logic             r_zero_done;
  logic             r_live;         // low only while reset is applied, so the request bus idles at 0
  logic [PTR_W-1:0] r_wptr, r_rptr;
  logic [CNT_W-1:0] r_count;
  logic [31:0]      r_mem [FIFO_DEPTH];

  logic             w_issue, w_accept, w_last_pop, w_valid, w_pop;
  logic [CNT_W:0]   w_occ;
  logic [31:0]      w_incr;

`ifdef CONV1D_SRAM_RD_STRIDE_EN
  logic [15:0]      r_stride;
  assign w_incr = {16'h0000, r_stride & 16'hFFFC};
`else
  assign w_incr = 32'd4;
`endif

  assign w_valid = (r_count != '0);
  assign w_pop   = w_valid && ready_i;
  // Words buffered plus the one response that may still land next edge.
  assign w_occ   = {1'b0, r_count} + {{CNT_W{1'b0}}, r_rsp_vld_p1};

  // ---- control: state register ----
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_accept    = 1'b0;
    w_last_pop  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_accept = 1'b1;
          if (len_i != '0) w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if ((r_issue_rem != '0) && (w_occ < DEPTH_L)) begin
          w_issue = 1'b1;
          if (r_issue_rem == LEN_W'(1)) w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_pop && (r_pop_rem == LEN_W'(1))) begin
          w_last_pop  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---- stage p0: issue address / counters, p1: response capture ----
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_addr       <= '0;
      r_issue_rem  <= '0;
      r_pop_rem    <= '0;
      r_rsp_vld_p1 <= 1'b0;
      r_zero_done  <= 1'b0;
      r_live       <= 1'b0;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
`ifdef CONV1D_SRAM_RD_STRIDE_EN
      r_stride     <= '0;
`endif
    end else begin
      r_live       <= 1'b1;
      r_rsp_vld_p1 <= w_issue;
      r_zero_done  <= w_accept && (len_i == '0);
      if (w_accept && (len_i != '0)) begin
        r_addr      <= base_addr_i & ~32'h3;
        r_issue_rem <= len_i;
        r_pop_rem   <= len_i;
`ifdef CONV1D_SRAM_RD_STRIDE_EN
        r_stride    <= stride_i;
`endif
      end else begin
        if (w_issue) begin
          r_addr      <= r_addr + w_incr;
          r_issue_rem <= r_issue_rem - LEN_W'(1);
        end
        if (w_pop) r_pop_rem <= r_pop_rem - LEN_W'(1);
      end
      if (r_rsp_vld_p1) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)        r_rptr <= r_rptr + PTR_W'(1);
      case ({r_rsp_vld_p1, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage is data only; occupancy lives in the reset control above.
  always_ff @(posedge clk_i) begin
    if (r_rsp_vld_p1) r_mem[r_wptr] <= sram_rsp_i;
  end

  // ---- outputs ----
  assign busy_o     = (r_state != S_IDLE);
  assign done_o     = w_last_pop | r_zero_done;
  assign valid_o    = w_valid;
  assign data_o     = w_valid ? r_mem[r_rptr] : 32'h0;
  assign sram_req_o = {w_issue, 1'b0, {4{r_live}}, r_addr, 32'h0000_0000};

endmodule

// File: tb/tb_conv1d_sram_reader.sv
module tb_conv1d_sram_reader;

  localparam int FIFO_DEPTH = 4;
  localparam int LEN_W      = 16;

  logic             clk = 1'b0;
  logic             rst_i;
  logic             start_i;
  logic [31:0]      base_addr_i;
  logic [LEN_W-1:0] len_i;
`ifdef CONV1D_SRAM_RD_STRIDE_EN
  logic [15:0]      stride_i;
`endif
  logic             busy_o, done_o, valid_o, ready_i;
  logic [69:0]      sram_req_o;
  logic [31:0]      sram_rsp_i = 32'hDEADBEEF;
  logic [31:0]      data_o;

  conv1d_sram_reader #(.FIFO_DEPTH(FIFO_DEPTH), .LEN_W(LEN_W)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
    .base_addr_i(base_addr_i), .len_i(len_i),
`ifdef CONV1D_SRAM_RD_STRIDE_EN
    .stride_i(stride_i),
`endif
    .busy_o(busy_o), .done_o(done_o), .sram_req_o(sram_req_o),
    .sram_rsp_i(sram_rsp_i), .data_o(data_o), .valid_o(valid_o),
    .ready_i(ready_i)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int req_cnt = 0;
  int done_cnt = 0;
  int exp_dones = 0;
  int left = 0;
  bit zexp = 1'b0;
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];

  // Memory contents are a fixed function of the word address.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  task automatic chk(input string nm, input logic [69:0] act, input logic [69:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic fail_now(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s", nm);
  endtask

  // SRAM model: data for a request appears exactly one cycle later.
  always @(posedge clk)
    sram_rsp_i <= sram_req_o[69] ? memf(sram_req_o[63:32]) : 32'hDEADBEEF;

  // Monitor / scoreboard
  logic [31:0] mon_ea, mon_ed;
  logic        mon_hs, mon_done;
  always @(negedge clk) begin
    if (!rst_i) begin
      if (sram_req_o[69]) begin
        req_cnt++;
        if (exp_addr.size() == 0) fail_now("unexpected_req");
        else begin
          mon_ea = exp_addr.pop_front();
          chk("req_addr", {38'h0, sram_req_o[63:32]}, {38'h0, mon_ea});
          chk("req_consts", {33'h0, sram_req_o[68:64], sram_req_o[31:0]},
              {33'h0, 1'b0, 4'hF, 32'h0});
        end
      end
      mon_hs   = valid_o && ready_i;
      mon_done = zexp || (mon_hs && left == 1);
      zexp     = 1'b0;
      if (mon_hs) begin
        if (exp_data.size() == 0) fail_now("unexpected_data");
        else begin
          mon_ed = exp_data.pop_front();
          chk("stream_data", {38'h0, data_o}, {38'h0, mon_ed});
        end
        left--;
      end
      chk("done_timing", {69'h0, done_o}, {69'h0, mon_done});
      if (done_o) done_cnt++;
    end
  end

  // Reference: word i of a transfer lives at (base & ~3) + i*incr, mod 2^32.
  task automatic do_start(input logic [31:0] base, input int len, input logic [15:0] stride);
    logic [31:0] b, incr;
    b = base & ~32'h3;
`ifdef CONV1D_SRAM_RD_STRIDE_EN
    incr = {16'h0, stride & 16'hFFFC};
`else
    incr = 32'd4 + {16'h0, stride & 16'h0};
`endif
    for (int i = 0; i < len; i++) begin
      exp_addr.push_back(b + incr * i);
      exp_data.push_back(memf(b + incr * i));
    end
    left = len;
    exp_dones++;
    @(posedge clk); #1;
    base_addr_i = base;
    len_i = len[LEN_W-1:0];
`ifdef CONV1D_SRAM_RD_STRIDE_EN
    stride_i = stride;
`endif
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    if (len == 0) zexp = 1'b1;
  endtask

  task automatic wait_done(input int budget, input bit rnd);
    int n = 0;
    do begin
      @(posedge clk); #1;
      if (rnd) ready_i = ($urandom_range(0, 3) != 0);
      n++;
    end while (done_cnt < exp_dones && n < budget);
    if (done_cnt < exp_dones) fail_now("done_timeout");
    else chk("busy_after_done", {69'h0, busy_o}, 70'h0);
    ready_i = 1'b1;
    chk("addr_q_empty", 70'(exp_addr.size()), 70'h0);
    chk("data_q_empty", 70'(exp_data.size()), 70'h0);
  endtask

  task automatic chk_all_zero(input string nm);
    chk(nm, {sram_req_o[69:1] | {data_o, 37'h0}, sram_req_o[0] | busy_o | done_o | valid_o}, 70'h0);
  endtask

  initial begin
    int r0, n;
    logic [31:0] rb;
    rst_i = 1'b1; start_i = 1'b0; base_addr_i = '0; len_i = '0; ready_i = 1'b1;
`ifdef CONV1D_SRAM_RD_STRIDE_EN
    stride_i = '0;
`endif
    #1 chk_all_zero("reset_outputs");
    @(posedge clk); @(posedge clk); #1 rst_i = 1'b0;
    chk("idle_busy", {69'h0, busy_o}, 70'h0);

    // Basic read with exact cycle timing
    do_start(32'h100, 4, 16'h4);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("basic_req_cycle", {69'h0, sram_req_o[69]}, {69'h0, (k < 4)});
      chk("basic_valid_cycle", {69'h0, valid_o}, {69'h0, (k >= 2)});
    end
    wait_done(50, 1'b0);

    // Backpressure: FIFO fills, issue stops at FIFO_DEPTH requests
    ready_i = 1'b0;
    r0 = req_cnt;
    do_start(32'h2000, 8, 16'h4);
    repeat (20) @(posedge clk);
    #1;
    chk("bp_req_count", 70'(req_cnt - r0), 70'(FIFO_DEPTH));
    chk("bp_req_low", {69'h0, sram_req_o[69]}, 70'h0);
    chk("bp_valid", {69'h0, valid_o}, 70'h1);
    ready_i = 1'b1;
    wait_done(100, 1'b0);

    // Zero length
    r0 = req_cnt;
    do_start(32'h300, 0, 16'h4);
    chk("zero_busy", {69'h0, busy_o}, 70'h0);
    wait_done(10, 1'b0);
    chk("zero_no_req", 70'(req_cnt - r0), 70'h0);

    // Start while busy is ignored
    do_start(32'h500, 6, 16'h4);
    @(posedge clk); #1;
    base_addr_i = 32'h800; len_i = 3; start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
    wait_done(100, 1'b0);

    // Reset mid-transfer
    r0 = req_cnt;
    do_start(32'h1000, 8, 16'h4);
    exp_dones--;
    n = 0;
    do begin @(posedge clk); #2; n++; end while (req_cnt - r0 < 3 && n < 40);
    if (req_cnt - r0 < 3) fail_now("rst_wait_timeout");
    rst_i = 1'b1;
    #1 chk_all_zero("midrst_outputs");
    exp_addr.delete(); exp_data.delete(); left = 0; zexp = 1'b0;
    @(posedge clk); #1 rst_i = 1'b0;
    r0 = req_cnt;
    do_start(32'h40, 2, 16'h4);
    wait_done(50, 1'b0);
    chk("post_rst_req_count", 70'(req_cnt - r0), 70'h2);

`ifdef CONV1D_SRAM_RD_STRIDE_EN
    do_start(32'h0, 3, 16'h10);
    wait_done(50, 1'b0);
    do_start(32'h0, 3, 16'h13);
    wait_done(50, 1'b0);
`endif

    // Address wrap at 2^32
    do_start(32'hFFFF_FFF9, 4, 16'h4);
    wait_done(50, 1'b1);

    // Randomized transfers with random backpressure
    for (int t = 0; t < 12; t++) begin
      rb = $urandom;
      do_start(rb, $urandom_range(1, 10), 16'($urandom_range(0, 64)));
      wait_done(400, 1'b1);
    end

    chk("done_total", 70'(done_cnt), 70'(exp_dones));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
